// File: rtl/bch_t8_pkg.sv
// Shared sizing constants and FSM state encoding for the DVB-S2 normal-frame
// t=8 BCH parity engine.
package bch_t8_pkg;

  localparam int ROW_W     = 128;
  localparam int IN_W      = 16;
  localparam int ROM_AW    = 5;
  localparam int PAR_WORDS = ROW_W / IN_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/bch_gf2_row_acc.sv
// 128-bit GF(2) accumulator: conditionally XORs one ROM row per enabled cycle.
// o_acc_fold exposes the accumulator with the current row folded in.
module bch_gf2_row_acc
  import bch_t8_pkg::*;
(
  input  logic             clk_1x,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_sel,
  input  logic [ROW_W-1:0] i_row,
  output logic [ROW_W-1:0] o_acc_fold
);

  logic [ROW_W-1:0] r_acc;
  logic [ROW_W-1:0] w_term;

  assign w_term     = i_sel ? i_row : '0;
  assign o_acc_fold = r_acc ^ w_term;

  always_ff @(posedge clk_1x or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_acc_fold;
    end
  end

endmodule

// File: rtl/bch_normal_t8_iter_encoder.sv
// Iterative 16-bit-parallel BCH parity engine: one ROM row per cycle updates a
// 128-bit remainder, then the parity streams out as eight 16-bit words.
//
// state | meaning
// IDLE  | ready for an info word; latches feedback fb = r_top ^ s_data
// RD    | reads ROM rows 0..15, accumulating the row for fb[cnt-1]
// ACC   | folds row 15 and updates the remainder
// OUT   | streams parity words MSB first under m_ready backpressure
module bch_normal_t8_iter_encoder
  import bch_t8_pkg::*;
(
  input  logic              clk_1x,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [IN_W-1:0]   s_data,
  input  logic              s_last,
  output logic              rom_rd_en,
  output logic [ROM_AW-1:0] rom_rdaddr,
  input  logic [ROW_W-1:0]  rom_rd_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [IN_W-1:0]   m_data,
  output logic              m_last,
  output logic              busy
);

  localparam int CNT_W  = $clog2(IN_W);
  localparam int WCNT_W = $clog2(PAR_WORDS);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ROW_W-1:0]  r_rem;
  logic [ROW_W-1:0]  w_rem_nxt;
  logic [ROW_W-1:0]  w_acc_fold;
  logic [IN_W-1:0]   r_fb;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_sel_idx;
  logic              r_last_q;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_m_valid;
  logic [IN_W-1:0]   r_m_data;
  logic              r_m_last;
  logic              w_accept;
  logic              w_m_fire;
  logic              w_rd_done;
  logic              w_last_word;
  logic              w_acc_en;
  logic              w_acc_sel;

  assign w_accept    = s_valid && (r_state == IDLE);
  assign w_m_fire    = r_m_valid && m_ready;
  assign w_rd_done   = (r_state == RD) && (r_cnt == CNT_W'(IN_W - 1));
  assign w_last_word = (r_wcnt == WCNT_W'(PAR_WORDS - 1));
  assign w_sel_idx   = r_cnt - CNT_W'(1);

  // ROM data lags the address by one cycle, so RD cnt pairs with row cnt-1.
  assign w_acc_en  = (r_state == RD) && (r_cnt != '0);
  assign w_acc_sel = (r_state == ACC) ? r_fb[IN_W-1] : r_fb[w_sel_idx];
  assign w_rem_nxt = {r_rem[ROW_W-IN_W-1:0], {IN_W{1'b0}}} ^ w_acc_fold;

  bch_gf2_row_acc u_row_acc (
    .clk_1x     (clk_1x),
    .rst_n      (rst_n),
    .i_clr      (w_accept),
    .i_en       (w_acc_en),
    .i_sel      (w_acc_sel),
    .i_row      (rom_rd_q),
    .o_acc_fold (w_acc_fold)
  );

  always_ff @(posedge clk_1x or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    rom_rd_en   = 1'b0;
    rom_rdaddr  = '0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid) w_state_nxt = RD;
      end
      RD: begin
        rom_rd_en  = 1'b1;
        rom_rdaddr = ROM_AW'(r_cnt);
        if (w_rd_done) w_state_nxt = ACC;
      end
      ACC: begin
        w_state_nxt = r_last_q ? OUT : IDLE;
      end
      OUT: begin
        if (w_m_fire && w_last_word) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_1x or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_fb      <= '0;
      r_cnt     <= '0;
      r_last_q  <= 1'b0;
      r_wcnt    <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_fb     <= r_rem[ROW_W-1 -: IN_W] ^ s_data;
            r_last_q <= s_last;
            r_cnt    <= '0;
          end
        end
        RD: begin
          if (!w_rd_done) r_cnt <= r_cnt + CNT_W'(1);
        end
        ACC: begin
          r_rem <= w_rem_nxt;
          if (r_last_q) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_rem_nxt[ROW_W-1 -: IN_W];
            r_m_last  <= 1'b0;
            r_wcnt    <= '0;
          end
        end
        OUT: begin
          if (w_m_fire) begin
            if (w_last_word) begin
              r_rem     <= '0;
              r_wcnt    <= '0;
              r_m_valid <= 1'b0;
              r_m_data  <= '0;
              r_m_last  <= 1'b0;
            end else begin
              r_rem    <= {r_rem[ROW_W-IN_W-1:0], {IN_W{1'b0}}};
              r_wcnt   <= r_wcnt + WCNT_W'(1);
              r_m_data <= r_rem[ROW_W-IN_W-1 -: IN_W];
              r_m_last <= (r_wcnt == WCNT_W'(PAR_WORDS - 2));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;

endmodule

// File: tb/tb_bch_normal_t8_iter_encoder.sv
// Directed bench for the BCH t=8 parity engine with a 1-cycle-latency ROM
// model and an independent bit-serial LFSR reference.
module tb_bch_normal_t8_iter_encoder;

  localparam logic [127:0] ROW0 = 128'h5C510E47C7E52A0035C71DA8D6B91D6C;

  logic         clk_1x = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [15:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         rom_rd_en;
  logic [4:0]   rom_rdaddr;
  logic [127:0] rom_rd_q = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [15:0]  m_data;
  logic         m_last;
  logic         busy;

  logic [127:0] rom [32];
  int checks = 0;
  int errors = 0;

  always #5 clk_1x = ~clk_1x;

  always_ff @(posedge clk_1x) begin
    if (rom_rd_en) rom_rd_q <= rom[rom_rdaddr];
  end

  bch_normal_t8_iter_encoder dut (
    .clk_1x     (clk_1x),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .rom_rd_en  (rom_rd_en),
    .rom_rdaddr (rom_rdaddr),
    .rom_rd_q   (rom_rd_q),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
  );

  // Bit-serial LFSR, bit 15 first; ROW0 is x^128 mod g(x).
  function automatic logic [127:0] step(input logic [127:0] r, input logic [15:0] d);
    logic fbit;
    for (int b = 15; b >= 0; b--) begin
      fbit = r[127] ^ d[b];
      r = {r[126:0], 1'b0} ^ (fbit ? ROW0 : 128'h0);
    end
    return r;
  endfunction

  task automatic send_word(input logic [15:0] d, input logic l, output bit ok);
    int n = 0;
    ok = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 200) begin
      @(negedge clk_1x);
      n++;
    end
    if (s_ready) begin
      ok = 1;
      @(posedge clk_1x);
      #1;
    end
  endtask

  task automatic recv_parity(input int stall_w, input int stall_n, output logic [127:0] p,
                             output logic [7:0] lst, output bit ok, output bit stable);
    int n;
    logic [15:0] hold;
    ok = 1; stable = 1; p = '0; lst = '0;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      m_ready = 1'b0;
      @(negedge clk_1x);
      while (!m_valid && n < 200) begin
        @(negedge clk_1x);
        n++;
      end
      if (!m_valid) begin
        ok = 0;
        return;
      end
      if (k == stall_w) begin
        for (int c = 0; c < stall_n; c++) begin
          hold = m_data;
          @(negedge clk_1x);
          if (!m_valid || m_data !== hold) stable = 0;
        end
      end
      p[127-16*k -: 16] = m_data;
      lst[k] = m_last;
      m_ready = 1'b1;
      @(posedge clk_1x);
      #1;
      m_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic [25:0] obs;
    rst_n = 1'b0;
    #12;
    obs = {s_ready, rom_rd_en, rom_rdaddr, m_valid, m_data, m_last, busy};
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", obs, {1'b1, 1'b0, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0});
    end
    @(negedge clk_1x);
    rst_n = 1'b1;
    @(negedge clk_1x);
  endtask

  task automatic test_zero_frame;
    bit ok, okall, stable;
    logic [127:0] p;
    logic [7:0] lst;
    okall = 1;
    for (int k = 0; k < 4; k++) begin
      send_word(16'h0000, k == 3, ok);
      okall &= ok;
    end
    s_valid = 1'b0;
    checks++;
    if (!okall) begin errors++; $display("FAIL zero_accept got timeout exp accepted"); end
    recv_parity(-1, 0, p, lst, ok, stable);
    checks++;
    if (!ok || p !== 128'h0) begin
      errors++; $display("FAIL zero_parity got %h ok=%0d exp 0", p, ok);
    end
    checks++;
    if (lst !== 8'h80) begin errors++; $display("FAIL zero_mlast got %b exp 10000000", lst); end
    @(negedge clk_1x);
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_idle got m_valid=%b busy=%b exp 0 0", m_valid, busy);
    end
  endtask

  task automatic test_single_word;
    bit ok, sweep_ok, stable;
    logic [127:0] p;
    logic [7:0] lst;
    send_word(16'h0001, 1'b1, ok);
    s_valid = 1'b0;
    sweep_ok = ok;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk_1x);
      if (rom_rd_en !== (c < 16) || rom_rdaddr !== ((c < 16) ? 5'(c) : 5'd0) ||
          s_ready !== 1'b0 || busy !== 1'b1) begin
        sweep_ok = 0;
        $display("cycle %0d: rd_en=%b addr=%0d s_ready=%b busy=%b", c, rom_rd_en, rom_rdaddr, s_ready, busy);
      end
    end
    checks++;
    if (!sweep_ok) begin errors++; $display("FAIL single_sweep got bad sequence exp addr 0..15"); end
    recv_parity(-1, 0, p, lst, ok, stable);
    checks++;
    if (!ok || p !== 128'h5C510E47C7E52A0035C71DA8D6B91D6C) begin
      errors++; $display("FAIL single_parity got %h exp %h", p, 128'h5C510E47C7E52A0035C71DA8D6B91D6C);
    end
    checks++;
    if (lst !== 8'h80) begin errors++; $display("FAIL single_mlast got %b exp 10000000", lst); end
  endtask

  task automatic test_rate;
    bit ok, rate_ok, stable;
    logic [127:0] p;
    logic [7:0] lst;
    send_word(16'h0001, 1'b0, ok);
    s_valid = 1'b0;
    rate_ok = ok;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk_1x);
      if (s_ready !== (c == 17)) rate_ok = 0;
    end
    checks++;
    if (!rate_ok) begin errors++; $display("FAIL rate_ready got s_ready=%b at cycle 17 exp 17 low cycles", s_ready); end
    send_word(16'h0000, 1'b1, ok);
    s_valid = 1'b0;
    recv_parity(-1, 0, p, lst, ok, stable);
    checks++;
    if (!ok || p !== step(step(128'h0, 16'h0001), 16'h0000)) begin
      errors++; $display("FAIL rate_parity got %h exp %h", p, step(step(128'h0, 16'h0001), 16'h0000));
    end
  endtask

  task automatic test_linearity;
    bit ok, stable;
    logic [127:0] p, exp;
    logic [7:0] lst;
    logic [15:0] fr [3];
    send_word(16'h0003, 1'b1, ok);
    s_valid = 1'b0;
    recv_parity(-1, 0, p, lst, ok, stable);
    checks++;
    if (!ok || p !== (rom[0] ^ rom[1])) begin
      errors++; $display("FAIL lin_0003 got %h exp %h", p, rom[0] ^ rom[1]);
    end
    send_word(16'h8000, 1'b1, ok);
    s_valid = 1'b0;
    recv_parity(-1, 0, p, lst, ok, stable);
    checks++;
    if (!ok || p !== rom[15]) begin
      errors++; $display("FAIL lin_8000 got %h exp %h", p, rom[15]);
    end
    fr[0] = 16'hA5C3; fr[1] = 16'h0F0F; fr[2] = 16'h1234;
    exp = '0;
    for (int k = 0; k < 3; k++) begin
      send_word(fr[k], k == 2, ok);
      exp = step(exp, fr[k]);
    end
    s_valid = 1'b0;
    recv_parity(-1, 0, p, lst, ok, stable);
    checks++;
    if (!ok || p !== exp) begin
      errors++; $display("FAIL lin_multi got %h exp %h", p, exp);
    end
  endtask

  task automatic test_backpressure;
    bit ok, stable;
    logic [127:0] p;
    logic [7:0] lst;
    send_word(16'h1234, 1'b1, ok);
    s_valid = 1'b0;
    recv_parity(3, 10, p, lst, ok, stable);
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_stable got unstable m_data exp held"); end
    checks++;
    if (!ok || p !== step(128'h0, 16'h1234)) begin
      errors++; $display("FAIL bp_parity got %h exp %h", p, step(128'h0, 16'h1234));
    end
    checks++;
    if (lst !== 8'h80) begin errors++; $display("FAIL bp_mlast got %b exp 10000000", lst); end
  endtask

  task automatic test_reset_mid;
    bit ok, stable, found;
    logic [127:0] p;
    logic [7:0] lst;
    logic [25:0] obs;
    send_word(16'h0001, 1'b1, ok);
    s_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk_1x);
      if (rom_rd_en && rom_rdaddr == 5'd7) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_reach got no RD cnt=7 exp reached"); end
    #1 rst_n = 1'b0;
    #1;
    obs = {s_ready, rom_rd_en, rom_rdaddr, m_valid, m_data, m_last, busy};
    checks++;
    if (obs !== {1'b1, 1'b0, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset_outputs got %h exp %h", obs, {1'b1, 1'b0, 5'd0, 1'b0, 16'h0, 1'b0, 1'b0});
    end
    @(negedge clk_1x);
    rst_n = 1'b1;
    @(negedge clk_1x);
    send_word(16'h0001, 1'b1, ok);
    s_valid = 1'b0;
    recv_parity(-1, 0, p, lst, ok, stable);
    checks++;
    if (!ok || p !== ROW0) begin
      errors++; $display("FAIL mid_recover got %h exp %h", p, ROW0);
    end
  endtask

  task automatic test_back_to_back;
    bit ok, stable;
    logic [127:0] p, exp;
    logic [7:0] lst;
    logic [15:0] words [8];
    int lens [3];
    int idx;
    words[0] = 16'hDEAD; words[1] = 16'hBEEF; words[2] = 16'h0001; words[3] = 16'h8000;
    words[4] = 16'h7FFE; words[5] = 16'hFFFF; words[6] = 16'h5A5A; words[7] = 16'hC001;
    lens[0] = 2; lens[1] = 5; lens[2] = 1;
    idx = 0;
    for (int f = 0; f < 3; f++) begin
      exp = '0;
      for (int k = 0; k < lens[f]; k++) begin
        send_word(words[idx], k == lens[f] - 1, ok);
        exp = step(exp, words[idx]);
        idx++;
      end
      if (f == 2) s_valid = 1'b0;
      recv_parity(-1, 0, p, lst, ok, stable);
      checks++;
      if (!ok || p !== exp) begin
        errors++; $display("FAIL b2b_frame%0d got %h exp %h", f, p, exp);
      end
    end
    s_valid = 1'b0;
    @(negedge clk_1x);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b exp 0", busy); end
  endtask

  initial begin
    rom[0] = ROW0;
    for (int i = 1; i < 16; i++) rom[i] = {rom[i-1][126:0], 1'b0} ^ (rom[i-1][127] ? ROW0 : 128'h0);
    for (int i = 16; i < 32; i++) rom[i] = {4{32'hDEADBEEF}} ^ 128'(i);
    test_reset();
    test_zero_frame();
    test_single_word();
    test_rate();
    test_linearity();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
